// File: rtl/boruss_prog_mem_if.sv
// BORUSS program memory bus: read port plus streaming loader port.
// master drives requests and load words; slave is the memory.
interface boruss_prog_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              busy;
    logic              ld_done;
    logic              ld_err;

    modport master (
        output rd_en, rd_addr, ld_start, ld_len, ld_valid, ld_data,
        input  rd_data, rd_valid, ld_ready, busy, ld_done, ld_err
    );

    modport slave (
        input  rd_en, rd_addr, ld_start, ld_len, ld_valid, ld_data,
        output rd_data, rd_valid, ld_ready, busy, ld_done, ld_err
    );
endinterface

// File: rtl/boruss_prog_mem.sv
// BORUSS program memory: NOP-initialised word store with a burst loader.
// Reads are served only while the loader is idle; latency is one cycle.
module boruss_prog_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    boruss_prog_mem_if.slave bus
);
    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_en;
    logic              rd_acc;
    logic              rd_in_range;

    // Contents start as NOP at configuration and survive reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    // Loader sequencing: validate the request, count words, flag done/error.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    if (bus.ld_len != '0 && bus.ld_len <= DEPTH_L) begin
                        state_d = LOAD;
                        len_d   = bus.ld_len;
                        ptr_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // Pointer parks on the last word so a full load never wraps.
                    if (cnt_d == len_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_acc      = bus.rd_en && (state_q == IDLE);
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;

    // Read port next state: capture on accept, otherwise hold the data.
    always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_data_q;
        if (rd_acc) begin
            rd_data_d = rd_in_range ? mem_q[bus.rd_addr[IW-1:0]] : '0;
        end
    end

    // Control and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Word storage; deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q[IW-1:0]] <= bus.ld_data;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ld_ready = (state_q == LOAD);
    assign bus.busy     = (state_q != IDLE);
    assign bus.ld_done  = (state_q == DONE);
    assign bus.ld_err   = err_q;
endmodule

// File: doc/boruss_prog_mem.md
BORUSS_PROG_MEM -- requirements
Module: boruss_prog_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the instruction/data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, the address width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, the number of words; legal range 1..2**ADDR_W.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rd_en  input  1  read request.
REQ-007 SHALL have port rd_addr  input  ADDR_W  read address.
REQ-008 SHALL have port rd_data  output  DATA_W  registered read data.
REQ-009 SHALL have port rd_valid  output  1  rd_data holds the result of the previous cycle's accepted read.
REQ-010 SHALL have port ld_start  input  1  start-load pulse.
REQ-011 SHALL have port ld_len  input  ADDR_W+1  word count of the load, sampled with ld_start.
REQ-012 SHALL have port ld_valid  input  1  ld_data is valid.
REQ-013 SHALL have port ld_data  input  DATA_W  program word to store.
REQ-014 SHALL have port ld_ready  output  1  loader accepts a word this cycle.
REQ-015 SHALL have port busy  output  1  high while a load is in progress.
REQ-016 SHALL have port ld_done  output  1  one-cycle pulse at load completion.
REQ-017 SHALL have port ld_err  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-018 SHALL hold DEPTH words of DATA_W bits, initialised to all zeros (NOP) at configuration; reset SHALL NOT modify memory contents.
REQ-019 SHALL implement loader FSM states IDLE, LOAD, DONE.
REQ-020 IDLE: ld_start with 1 <= ld_len <= DEPTH SHALL go to LOAD, latch ld_len, and clear the write pointer to 0.
REQ-021 IDLE: ld_start with ld_len == 0 or ld_len > DEPTH SHALL pulse ld_err on the next cycle and remain in IDLE.
REQ-022 ld_ready SHALL equal (state == LOAD); busy SHALL equal (state != IDLE).
REQ-023 LOAD: each cycle with ld_valid && ld_ready SHALL write ld_data to mem[ptr], increment ptr, and increment the accepted-word count; cycles with ld_valid low SHALL write nothing.
REQ-024 LOAD: the accepted word that makes the count equal the latched length SHALL transition to DONE; no further words SHALL be accepted.
REQ-025 DONE SHALL last exactly one cycle, drive ld_done=1, and then return to IDLE.
REQ-026 ld_start SHALL be ignored in LOAD and in DONE, with no ld_err pulse.
REQ-027 A read SHALL be accepted when rd_en=1 and state == IDLE.
REQ-028 An accepted read SHALL register mem[rd_addr] into rd_data and set rd_valid=1 on the next rising edge (latency 1).
REQ-029 An accepted read with rd_addr >= DEPTH SHALL return all zeros (NOP) with rd_valid=1.
REQ-030 A cycle with no accepted read SHALL set rd_valid=0 and hold rd_data at its previous value.
REQ-031 rd_en in LOAD or DONE SHALL be dropped, not queued; the requester SHALL re-issue the read after busy falls.
REQ-032 A read accepted in the cycle after DONE SHALL return the newly loaded data.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, ptr=0, count=0, rd_data=0, rd_valid=0, ld_ready=0, busy=0, ld_done=0, ld_err=0.
REQ-034 Reset asserted during LOAD SHALL abort the load, keep the words already written, and produce no ld_done pulse.

Verification
REQ-035 Reset release followed by a read of address 0x05 -> one cycle later rd_valid=1 and rd_data=0x00.
REQ-036 ld_start with ld_len=3, then words 0x01, 0x02, 0x04 with one idle ld_valid gap -> ld_done pulses once after the third word; reads of 0..2 return 0x01, 0x02, 0x04; a read of 3 returns 0x00.
REQ-037 Load with ld_len=DEPTH (256) of words i^0xA5 -> ptr ends at 255 with no wrap, then the reads of 0 and 255 return 0xA5 and 0x5A.
REQ-038 ld_start with ld_len=0, then ld_len=257 -> ld_err pulses once each, busy stays 0, and memory is unchanged.
REQ-039 rd_en held high during a load, plus ld_start asserted mid-load -> rd_valid stays 0 and the second start is ignored; the first read after DONE returns the loaded value.
REQ-040 rst_n pulsed low after 2 of 4 words with DEPTH=16 -> all outputs are 0 and there is no ld_done; reads of 0..1 return the loaded words; a read of address 20 returns 0x00 with rd_valid=1.
